// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared constants, types and the BCD-to-segment decode for
//                the 2-digit multiplexed BCD display.
//                Segment byte order is {a,b,c,d,e,f,g,dp}, active-high.
//                dp is never lit.
//  Revision    : 1.0  initial release
// ============================================================================
package seg_pkg;

    localparam logic [7:0] SEG_0     = 8'hFC;
    localparam logic [7:0] SEG_1     = 8'h60;
    localparam logic [7:0] SEG_2     = 8'hDA;
    localparam logic [7:0] SEG_3     = 8'hF2;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'hB6;
    localparam logic [7:0] SEG_6     = 8'hBE;
    localparam logic [7:0] SEG_7     = 8'hE0;
    localparam logic [7:0] SEG_8     = 8'hFE;
    localparam logic [7:0] SEG_9     = 8'hF6;
    localparam logic [7:0] SEG_DASH  = 8'h02;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    localparam logic [1:0] DIG_TENS  = 2'b10;
    localparam logic [1:0] DIG_ONES  = 2'b01;

    // Overflow is stored in the shown-digit registers as a non-BCD code.
    // Every code 10..15 already decodes to a dash, and it can never be
    // mistaken for a leading zero.
    localparam logic [3:0] BCD_OVF   = 4'hA;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } conv_state_t;

    function automatic logic [7:0] seg_decode(input logic [3:0] bcd);
        logic [7:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage : seg_pkg
`default_nettype wire

// File: rtl/bcd_seq_conv.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_seq_conv
//  Description : Sequential shift-add-3 binary-to-BCD converter, one input
//                bit per clock. It goes IDLE -> SHIFT (VAL_W clk) -> COMMIT.
//                Ports:
//                  clk, res    clock, asynchronous active-high reset
//                  start       begin a conversion of bin (honoured in IDLE)
//                  bin         binary value to convert
//                  busy        high from the start edge until COMMIT ends
//                  done        high for the single COMMIT cycle
//                  hund        hundreds carry (non-zero means the value is > 99)
//                  tens, ones  BCD result, valid while done is high
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_seq_conv
    import seg_pkg::*;
#(
    parameter int VAL_W = 7
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic [VAL_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [1:0]       hund,
    output logic [3:0]       tens,
    output logic [3:0]       ones
);

    localparam int IDX_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(VAL_W - 1);

    conv_state_t      r_state;
    logic [VAL_W-1:0] r_sreg;
    logic [IDX_W-1:0] r_idx;
    logic [3:0]       w_tens_adj;
    logic [3:0]       w_ones_adj;

    // Add 3 before the shift, so that a digit >= 5 carries into the next
    // decade when it is doubled.
    assign w_tens_adj = (tens >= 4'd5) ? tens + 4'd3 : tens;
    assign w_ones_adj = (ones >= 4'd5) ? ones + 4'd3 : ones;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state <= IDLE;
            r_sreg  <= '0;
            r_idx   <= '0;
            hund    <= 2'd0;
            tens    <= 4'd0;
            ones    <= 4'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_sreg  <= bin;
                        r_idx   <= C_IDX_LAST;
                        hund    <= 2'd0;
                        tens    <= 4'd0;
                        ones    <= 4'd0;
                        busy    <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // {hund, tens, ones, sreg} shifts left by one bit.
                    hund   <= {hund[0], w_tens_adj[3]};
                    tens   <= {w_tens_adj[2:0], w_ones_adj[3]};
                    ones   <= {w_ones_adj[2:0], r_sreg[VAL_W-1]};
                    r_sreg <= {r_sreg[VAL_W-2:0], 1'b0};
                    if (r_idx == '0) begin
                        done    <= 1'b1;
                        r_state <= COMMIT;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                COMMIT: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : bcd_seq_conv
`default_nettype wire

// File: rtl/seg2_bcd_scan.sv
`default_nettype none
// ============================================================================
//  Module      : seg2_bcd_scan
//  Description : Converts a binary count to two BCD digits and drives them
//                onto a 2-digit multiplexed common-bus 7-segment display.
//                Values above 99 are shown as "--".
//                Ports:
//                  clk        system clock
//                  res        asynchronous active-high reset
//                  value      binary value, sampled every clock
//                  busy       a conversion is in progress
//                  digit_seg  {a,b,c,d,e,f,g,dp}, active-high
//                  digit_con  one-hot digit enable, 10 = tens, 01 = ones
//  Revision    : 1.0  initial release
// ============================================================================
module seg2_bcd_scan
    import seg_pkg::*;
#(
    parameter int VAL_W    = 7,
    parameter int SCAN_DIV = 10,
    parameter int BLANK_LZ = 0
) (
    input  logic             clk,
    input  logic             res,
    input  logic [VAL_W-1:0] value,
    output logic             busy,
    output logic [7:0]       digit_seg,
    output logic [1:0]       digit_con
);

    logic [VAL_W-1:0]    r_last_val;
    logic [3:0]          r_shown_tens;
    logic [3:0]          r_shown_ones;
    logic [SCAN_DIV-1:0] r_scan_cnt;

    logic                w_start;
    logic                w_done;
    logic [1:0]          w_hund;
    logic [3:0]          w_tens;
    logic [3:0]          w_ones;
    logic                w_wrap;
    logic [7:0]          w_tens_pat;
    logic [7:0]          w_ones_pat;

    // busy is low only in IDLE, so a changed value is picked up on the
    // first IDLE cycle after any conversion in flight finishes.
    assign w_start = !busy && (value != r_last_val);

    bcd_seq_conv #(
        .VAL_W (VAL_W)
    ) u_conv (
        .clk   (clk),
        .res   (res),
        .start (w_start),
        .bin   (value),
        .busy  (busy),
        .done  (w_done),
        .hund  (w_hund),
        .tens  (w_tens),
        .ones  (w_ones)
    );

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_last_val <= '0;
        end else if (w_start) begin
            r_last_val <= value;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_shown_tens <= 4'd0;
            r_shown_ones <= 4'd0;
        end else if (w_done) begin
            if (w_hund != 2'd0) begin
                r_shown_tens <= BCD_OVF;
                r_shown_ones <= BCD_OVF;
            end else begin
                r_shown_tens <= w_tens;
                r_shown_ones <= w_ones;
            end
        end
    end

    assign w_ones_pat = seg_decode(r_shown_ones);

    if (BLANK_LZ != 0) begin : g_blank_lz
        // The overflow code is never zero, so a dash is never blanked.
        assign w_tens_pat = (r_shown_tens == 4'd0) ? SEG_BLANK
                                                   : seg_decode(r_shown_tens);
    end else begin : g_show_lz
        assign w_tens_pat = seg_decode(r_shown_tens);
    end

    assign w_wrap = &r_scan_cnt;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_scan_cnt <= '0;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    // The enable and the segments are loaded on the same edge, so they never
    // disagree. A commit on the wrap edge is not seen until the next wrap,
    // because this block reads the shown registers before that edge updates them.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            digit_con <= DIG_ONES;
            digit_seg <= SEG_0;
        end else if (w_wrap) begin
            digit_con <= ~digit_con;
            digit_seg <= (digit_con == DIG_ONES) ? w_tens_pat : w_ones_pat;
        end
    end

endmodule : seg2_bcd_scan
`default_nettype wire

// File: tb/tb_seg2_bcd_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg2_bcd_scan
//  Description : Self-checking bench for seg2_bcd_scan (SCAN_DIV=3). The
//                stimulus pushes the expected display for each conversion.
//                A monitor pops an entry when busy falls. It also checks the
//                scan enable and the segments on every clock.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg2_bcd_scan;

    localparam int VAL_W    = 7;
    localparam int SCAN_DIV = 3;
    localparam int TB_BLANK = 0;
    localparam int SCAN_P   = 1 << SCAN_DIV;

    logic             clk = 1'b0;
    logic             res = 1'b1;
    logic [VAL_W-1:0] value = '0;
    logic             busy;
    logic [7:0]       digit_seg;
    logic [1:0]       digit_con;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] exp_q[$];
    int          last_req = 0;

    seg2_bcd_scan #(
        .VAL_W    (VAL_W),
        .SCAN_DIV (SCAN_DIV),
        .BLANK_LZ (TB_BLANK)
    ) dut (
        .clk       (clk),
        .res       (res),
        .value     (value),
        .busy      (busy),
        .digit_seg (digit_seg),
        .digit_con (digit_con)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pat(input int d);
        case (d)
            0: return 8'hFC;
            1: return 8'h60;
            2: return 8'hDA;
            3: return 8'hF2;
            4: return 8'h66;
            5: return 8'hB6;
            6: return 8'hBE;
            7: return 8'hE0;
            8: return 8'hFE;
            9: return 8'hF6;
            default: return 8'h02;
        endcase
    endfunction

    // {tens pattern, ones pattern} that the display must show for value v.
    function automatic logic [15:0] exp_pair(input int v);
        logic [7:0] tp;
        if (v > 99) return {8'h02, 8'h02};
        tp = (TB_BLANK != 0 && v / 10 == 0) ? 8'h00 : pat(v / 10);
        return {tp, pat(v % 10)};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [1:0] exp_con;
        logic [7:0] exp_seg;
        logic [15:0] shown;
        logic [15:0] popped;
        logic       prev_busy;
        int         edges;
        int         run;
        exp_con   = 2'b01;
        exp_seg   = 8'hFC;
        shown     = exp_pair(0);
        prev_busy = 1'b0;
        edges     = 0;
        run       = 0;
        forever begin
            @(negedge clk);
            if (res) begin
                check("reset_busy", {31'd0, busy}, 32'd0);
                check("reset_con", {30'd0, digit_con}, 32'h1);
                check("reset_seg", {24'd0, digit_seg}, 32'hFC);
                exp_con   = 2'b01;
                exp_seg   = 8'hFC;
                shown     = exp_pair(0);
                prev_busy = 1'b0;
                edges     = 0;
                run       = 0;
            end else begin
                edges++;
                if (edges % SCAN_P == 0) begin
                    exp_con = ~exp_con;
                    exp_seg = (exp_con == 2'b10) ? shown[15:8] : shown[7:0];
                end
                check("con_onehot", {31'd0, $onehot(digit_con)}, 32'd1);
                check("digit_con", {30'd0, digit_con}, {30'd0, exp_con});
                check("digit_seg", {24'd0, digit_seg}, {24'd0, exp_seg});
                if (busy) run++;
                if (prev_busy && !busy) begin
                    check("busy_len", run, VAL_W + 1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_conv", 32'd1, 32'd0);
                    end else begin
                        popped = exp_q.pop_front();
                        shown  = popped;
                    end
                    run = 0;
                end
                prev_busy = busy;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic apply(input int v);
        @(negedge clk);
        value = VAL_W'(v);
        if (v != last_req) begin
            exp_q.push_back(exp_pair(v));
            last_req = v;
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 32'd1, 32'd0);
        // Two wraps or more, so both digits are shown with the new data.
        repeat (2 * SCAN_P + 4) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, then value 0 held: no conversion, FC on both digits.
        repeat (3) @(negedge clk);
        #2 res = 1'b0;
        repeat (5 * SCAN_P) @(negedge clk);

        apply(42);
        wait_idle();

        apply(99);
        wait_idle();
        apply(100);
        wait_idle();
        apply(127);
        wait_idle();

        // A change during the conversion is converted after the first one.
        apply(5);
        repeat (3) @(negedge clk);
        apply(37);
        wait_idle();

        // Asynchronous reset during SHIFT.
        apply(88);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 res = 1'b1;
        #1;
        check("async_busy", {31'd0, busy}, 32'd0);
        check("async_con", {30'd0, digit_con}, 32'h1);
        check("async_seg", {24'd0, digit_seg}, 32'hFC);
        exp_q.delete();
        last_req = 0;
        repeat (3) @(negedge clk);
        #2 res = 1'b0;
        exp_q.push_back(exp_pair(88));
        last_req = 88;
        wait_idle();

        // Random values. A value repeated in a row must not start a conversion.
        for (int k = 0; k < 20; k++) begin
            int v;
            v = (k % 7 == 3) ? last_req : int'($urandom_range(0, 127));
            apply(v);
            wait_idle();
            repeat ($urandom_range(0, 10)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_seg2_bcd_scan
`default_nettype wire
